// File: rtl/conv_adder_tree.sv
// Pipelined signed adder tree: sums KERNEL_SIZE^2 products, adds bias, saturates.
// One window per cycle; a single advance signal stalls every stage together.
module conv_adder_tree #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BIT    = 8,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] products,
  input  logic [DATA_WIDTH-1:0]                       bias,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [DATA_WIDTH-1:0]                       result
);

  localparam int N         = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(N + 1);
  localparam int L         = $clog2(N);
  localparam int NP        = N + 1;
  localparam int HALF      = (N + 1) / 2;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Operands and result share one fixed-point format, so the binary point never moves.
  if (FRAC_BIT < 0 || FRAC_BIT >= DATA_WIDTH) begin : g_frac_bit_out_of_word
  end

  function automatic int level_count(input int lvl);
    int c;
    c = N;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  logic signed [ACC_WIDTH-1:0] ext_d  [0:NP-1];
  logic signed [ACC_WIDTH-1:0] tree_q [0:L][0:NP-1];
  logic signed [ACC_WIDTH-1:0] bias_q [0:L];
  logic [L:0]                  vld_q;
  logic                        advance;
  logic signed [ACC_WIDTH-1:0] total_d;
  logic [DATA_WIDTH-1:0]       sat_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_ext
    assign ext_d[gi] = ACC_WIDTH'($signed(products[gi*DATA_WIDTH +: DATA_WIDTH]));
  end
  // Spare slot keeps pair indexing in range when N is odd.
  assign ext_d[N] = '0;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    total_d = tree_q[L][0] + bias_q[L];
    sat_d   = total_d[DATA_WIDTH-1:0];
    if (total_d > SAT_MAX) begin
      sat_d = SAT_MAX[DATA_WIDTH-1:0];
    end else if (total_d < SAT_MIN) begin
      sat_d = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l <= L; l++) begin
        bias_q[l] <= '0;
        for (int j = 0; j < NP; j++) tree_q[l][j] <= '0;
      end
      vld_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (advance) begin
      vld_q[0]  <= in_valid;
      bias_q[0] <= ACC_WIDTH'($signed(bias));
      for (int j = 0; j < NP; j++) tree_q[0][j] <= ext_d[j];
      for (int l = 1; l <= L; l++) begin
        vld_q[l]  <= vld_q[l-1];
        bias_q[l] <= bias_q[l-1];
        for (int j = 0; j < HALF; j++) begin
          if (2*j + 1 < level_count(l-1)) begin
            tree_q[l][j] <= tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
          end else if (2*j < level_count(l-1)) begin
            tree_q[l][j] <= tree_q[l-1][2*j];
          end else begin
            tree_q[l][j] <= '0;
          end
        end
        for (int j = HALF; j < NP; j++) tree_q[l][j] <= '0;
      end
      out_valid <= vld_q[L];
      result    <= sat_d;
    end
  end

endmodule

// File: tb/tb_conv_adder_tree.sv
// Directed bench for conv_adder_tree: single windows, saturation edges,
// streaming under backpressure and reset flush.
module tb_conv_adder_tree;

  localparam int DW = 16;
  localparam int N  = 25;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   products;
  logic [DW-1:0]     bias;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     result;

  int n_cmp = 0;
  int n_bad = 0;

  conv_adder_tree #(.DATA_WIDTH(16), .FRAC_BIT(8), .KERNEL_SIZE(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .products  (products),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) products[i*DW +: DW] = v;
  endtask

  // One isolated window through an empty pipeline with out_ready high.
  task automatic run_one(input string tag, input logic [DW-1:0] exp);
    int n;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, n, 7);
    check_eq({tag, "_result"}, int'(result), int'(exp));
    tick();
    check_eq({tag, "_pulse"}, int'(out_valid), 0);
  endtask

  initial begin
    int k, rcv, stall_left, gaps, seen;
    logic first_seen, acc;
    logic [DW-1:0] held;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bias = '0; products = '0;
    tick();
    tick();
    check_eq("reset_out_valid", int'(out_valid), 0);
    check_eq("reset_result", int'(result), 0);
    check_eq("reset_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    tick();

    set_all(16'h0100); bias = 16'h0000;
    run_one("unit_sum", 16'h1900);

    set_all(16'h7FFF); bias = 16'h7FFF;
    run_one("pos_sat", 16'h7FFF);

    set_all(16'h8000); bias = 16'h8000;
    run_one("neg_sat", 16'h8000);

    set_all(16'h0200);
    for (int i = 13; i < N; i++) products[i*DW +: DW] = 16'hFE00;
    bias = 16'hFF80;
    run_one("mixed", 16'h0180);

    set_all(16'h0500); bias = 16'h02FF;
    run_one("exact_max", 16'h7FFF);
    set_all(16'h0500); bias = 16'h0300;
    run_one("max_plus_one", 16'h7FFF);
    set_all(16'hFB00); bias = 16'hFD00;
    run_one("exact_min", 16'h8000);
    set_all(16'hFB00); bias = 16'hFCFF;
    run_one("min_minus_one", 16'h8000);
    set_all(16'hFF00); bias = 16'h0000;
    run_one("neg_small", 16'hE700);

    // Streaming: 10 back-to-back windows, 3-cycle stall on first output.
    k = 1; set_all(16'(k * 16'h0010)); bias = '0; in_valid = 1'b1;
    rcv = 0; stall_left = 0; gaps = 0; first_seen = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        stall_left = 3;
        held = result;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        check_eq("stall_in_ready", int'(in_ready), 0);
        check_eq("stall_hold", int'(result), int'(held));
        stall_left--;
      end else if (first_seen && !out_valid) begin
        gaps++;
      end
      if (out_valid && out_ready) begin
        check_eq($sformatf("stream_out%0d", rcv), int'(result), (rcv + 1) * 16'h0190);
        rcv++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        if (k < 10) begin
          k++;
          set_all(16'(k * 16'h0010));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b1;
    check_eq("stream_count", rcv, 10);
    check_eq("stream_gaps", gaps, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check_eq("stream_no_dup", seen, 0);

    // Reset flush: 4 windows in flight, inputs during reset are dropped.
    set_all(16'h0040); bias = '0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    set_all(16'h0100);
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check_eq("rst_flush_valid", int'(out_valid), 0);
    check_eq("rst_flush_result", int'(result), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check_eq("rst_no_stale", seen, 0);

    set_all(16'h0020); bias = 16'h0100;
    run_one("post_reset", 16'h0420);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_adder_tree.md
Name: conv_adder_tree

Overview:
- Downstream of the per-tap multiplier array in the convolver datapath.
- Takes the KERNEL_SIZE² fixed-point products of one window plus one bias word.
- Sums them in a registered, pipelined binary adder tree, adds the bias, saturates to DATA_WIDTH and presents one convolution output per window.
- Valid/ready handshake on both sides with full-pipeline stall under backpressure.

Parameters:
- DATA_WIDTH, 16, width of each product, bias and result word (signed two's complement).
- FRAC_BIT, 8, fractional bits of the fixed-point format. Products, bias and result share the same format, so no shift occurs in this block.
- KERNEL_SIZE, 5, kernel edge. Number of taps N = KERNEL_SIZE**2.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  products and bias valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- products  input  N*DATA_WIDTH  tap i in bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- bias  input  DATA_WIDTH  signed bias, sampled with products.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  DATA_WIDTH  saturated signed sum.

Behaviour:
- Internal widths:
  - ACC_WIDTH = DATA_WIDTH + clog2(N+1), which is 21 for defaults.
  - All operands are sign-extended to ACC_WIDTH, so no intermediate overflow is possible.
- Pipeline structure:
  - Stage 0 registers the N sign-extended products and the bias.
  - Levels 1..L, with L = clog2(N) (5 for N=25), each add adjacent pairs and register the sums.
  - An odd element at any level passes through registered, unchanged.
  - The final stage adds the bias to the tree root, saturates and registers result.
- Latency: LATENCY = L + 2 cycles from the accepting edge to out_valid high (7 for defaults) when not stalled.
- Saturation:
  - If sum > 2^(DATA_WIDTH-1)-1, result = 0x7FFF.
  - If sum < -2^(DATA_WIDTH-1), result = 0x8000.
  - Otherwise result is the low DATA_WIDTH bits of the sum.
  - No rounding.
- Valid tracking: a per-stage valid bit travels with the data. Bubbles propagate as valid=0.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance. It is combinational and must not depend on in_valid.
  - An input transfer occurs when in_valid & in_ready.
  - When advance=1, every stage loads from its predecessor, and stage 0 valid takes in_valid.
  - When advance=0, every stage, result and out_valid hold. Inputs are ignored and nothing is dropped.
  - An output transfer occurs when out_valid & out_ready. Simultaneous output and input transfers in the same cycle are legal, giving full throughput of one window per cycle.
- Reset:
  - All valid bits clear, out_valid = 0 and result = 0 on the edge where reset=1. Data registers may also clear.
  - Reset mid-operation discards all in-flight windows. No stale output may appear afterwards.
  - in_ready reads 1 while reset is asserted, since out_valid is 0 after the first reset edge. Inputs presented during reset are discarded.
- result is stable and must not change while out_valid=1 and out_ready=0.
- No combinational path from products or bias to any output.

Test Plan:
- **Unit sum:** all 25 products = 0x0100 (1.0), bias = 0x0000, out_ready=1, one in_valid pulse.
  - Expect result = 0x1900 (25.0), exactly 7 cycles later, out_valid high for exactly 1 cycle.
- **Positive saturation:** all products = 0x7FFF, bias = 0x7FFF.
  - Expect result = 0x7FFF.
- **Negative saturation:** all products = 0x8000, bias = 0x8000.
  - Expect result = 0x8000.
- **Mixed signs with bias:** taps 0..12 = 0x0200 (2.0), taps 13..24 = 0xFE00 (-2.0), bias = 0xFF80 (-0.5).
  - Expect result = 0x0180 (1.5).
- **Streaming with backpressure:**
  - Stimulus: 10 back-to-back windows, window k with all products = k*0x0010, bias 0. Deassert out_ready for 3 cycles once the first output appears.
  - Expect in_ready low during the stall and result held. Outputs must be k*0x0190, in order, with none lost or duplicated. Throughput returns to 1 per cycle after out_ready rises.
- **Reset mid-operation:**
  - Stimulus: 4 windows in flight, then assert reset for 1 cycle.
  - Expect out_valid = 0 and result = 0 after the reset edge, and no output from the flushed windows ever appears. A new window after reset emerges after 7 cycles with the correct sum.
